// File: rtl/cpu_core_mc_if.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_core_mc_if
//  Purpose  : Instruction-memory fetch bus (req/valid handshake) between
//             cpu_core_mc (master) and the instruction memory (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface cpu_core_mc_if #(
  parameter int PC_WIDTH = 8
);
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_valid;
  logic [15:0]         imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/cpu_core_mc.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_core_mc
//  Purpose  : Multi-cycle CPU core. Fetches 16-bit instructions over a
//             req/valid bus, executes against 8 registers, drives an output
//             port with a valid strobe, zero/carry flags and a halt state.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_core_mc #(
  parameter int DATA_WIDTH = 8,
  parameter int PC_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  cpu_core_mc_if.master         imem,
  output logic [DATA_WIDTH-1:0] core_output,
  output logic                  out_valid,
  output logic                  halted,
  output logic                  flag_z,
  output logic                  flag_c,
  output logic                  illegal
);

  localparam logic [1:0] c_FETCH  = 2'd0;
  localparam logic [1:0] c_WAIT   = 2'd1;
  localparam logic [1:0] c_EXEC   = 2'd2;
  localparam logic [1:0] c_HALTED = 2'd3;

  localparam logic [3:0] c_OP_ADD  = 4'd1;
  localparam logic [3:0] c_OP_SUB  = 4'd2;
  localparam logic [3:0] c_OP_AND  = 4'd3;
  localparam logic [3:0] c_OP_OR   = 4'd4;
  localparam logic [3:0] c_OP_XOR  = 4'd5;
  localparam logic [3:0] c_OP_ADDI = 4'd6;
  localparam logic [3:0] c_OP_LDI  = 4'd7;
  localparam logic [3:0] c_OP_OUT  = 4'd8;
  localparam logic [3:0] c_OP_JMP  = 4'd9;
  localparam logic [3:0] c_OP_BEQZ = 4'd10;
  localparam logic [3:0] c_OP_HALT = 4'd15;

  logic [1:0]            r_state;
  logic [PC_WIDTH-1:0]   r_pc;
  logic [15:0]           r_ir;
  logic [DATA_WIDTH-1:0] r_regs [0:7];
  logic [DATA_WIDTH-1:0] r_out;
  logic                  r_out_valid;
  logic                  r_halted;
  logic                  r_flag_z;
  logic                  r_flag_c;
  logic                  r_illegal;

  // Instruction fields
  logic [3:0]            w_op;
  logic [2:0]            w_rd;
  logic [2:0]            w_rs1;
  logic [2:0]            w_rs2;
  logic [DATA_WIDTH-1:0] w_a;
  logic [DATA_WIDTH-1:0] w_b;
  logic [DATA_WIDTH-1:0] w_d;
  logic [DATA_WIDTH-1:0] w_simm;
  logic [DATA_WIDTH-1:0] w_zimm;
  logic [PC_WIDTH-1:0]   w_target;

  assign w_op     = r_ir[15:12];
  assign w_rd     = r_ir[11:9];
  assign w_rs1    = r_ir[8:6];
  assign w_rs2    = r_ir[5:3];
  assign w_a      = r_regs[w_rs1];
  assign w_b      = r_regs[w_rs2];
  assign w_d      = r_regs[w_rd];
  assign w_simm   = DATA_WIDTH'(signed'(r_ir[5:0]));
  assign w_zimm   = DATA_WIDTH'(r_ir[8:0]);
  assign w_target = r_ir[PC_WIDTH-1:0];

  // ALU / writeback decode; the extra top bit of w_ext carries out or borrows
  logic [DATA_WIDTH:0]   w_ext;
  logic [DATA_WIDTH-1:0] w_res;
  logic                  w_we;
  logic                  w_c_next;
  logic                  w_illegal_op;
  logic [PC_WIDTH-1:0]   w_pc_next;

  // Combinational execute datapath for the instruction held in IR
  always_comb begin
    w_ext        = '0;
    w_res        = '0;
    w_we         = 1'b0;
    w_c_next     = r_flag_c;
    w_illegal_op = 1'b0;
    w_pc_next    = r_pc + PC_WIDTH'(1);
    case (w_op)
      c_OP_ADD: begin
        w_ext = {1'b0, w_a} + {1'b0, w_b};
        w_res = w_ext[DATA_WIDTH-1:0]; w_c_next = w_ext[DATA_WIDTH]; w_we = 1'b1;
      end
      c_OP_SUB: begin
        w_ext = {1'b0, w_a} - {1'b0, w_b};
        w_res = w_ext[DATA_WIDTH-1:0]; w_c_next = w_ext[DATA_WIDTH]; w_we = 1'b1;
      end
      c_OP_AND:  begin w_res = w_a & w_b; w_c_next = 1'b0; w_we = 1'b1; end
      c_OP_OR:   begin w_res = w_a | w_b; w_c_next = 1'b0; w_we = 1'b1; end
      c_OP_XOR:  begin w_res = w_a ^ w_b; w_c_next = 1'b0; w_we = 1'b1; end
      c_OP_ADDI: begin
        w_ext = {1'b0, w_a} + {1'b0, w_simm};
        w_res = w_ext[DATA_WIDTH-1:0]; w_c_next = w_ext[DATA_WIDTH]; w_we = 1'b1;
      end
      c_OP_LDI:  begin w_res = w_zimm; w_c_next = 1'b0; w_we = 1'b1; end
      c_OP_JMP:  w_pc_next = w_target;
      c_OP_BEQZ: if (w_d == '0) w_pc_next = w_target;
      4'd11, 4'd12, 4'd13, 4'd14: w_illegal_op = 1'b1;
      default: ;
    endcase
  end

  // Fetch/wait/execute sequencer with register file, flag and output state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_FETCH;
      r_pc        <= '0;
      r_ir        <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_halted    <= 1'b0;
      r_flag_z    <= 1'b0;
      r_flag_c    <= 1'b0;
      r_illegal   <= 1'b0;
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
      case (r_state)
        c_FETCH: r_state <= c_WAIT;
        c_WAIT: begin
          if (imem.imem_valid) begin
            r_ir    <= imem.imem_rdata;
            r_state <= c_EXEC;
          end
        end
        c_EXEC: begin
          r_pc <= w_pc_next;
          if (w_we) begin
            r_regs[w_rd] <= w_res;
            r_flag_z     <= (w_res == '0);
            r_flag_c     <= w_c_next;
          end
          if (w_op == c_OP_OUT) begin
            r_out       <= w_a;
            r_out_valid <= 1'b1;
          end
          r_illegal <= w_illegal_op;
          if (w_op == c_OP_HALT) begin
            r_halted <= 1'b1;
            r_state  <= c_HALTED;
          end else begin
            r_state  <= c_FETCH;
          end
        end
        default: r_state <= c_HALTED;
      endcase
    end
  end

  // Request is masked while reset is held so no fetch escapes during reset
  assign imem.imem_req  = (r_state == c_FETCH) & ~rst;
  assign imem.imem_addr = r_pc;
  assign core_output    = r_out;
  assign out_valid      = r_out_valid;
  assign halted         = r_halted;
  assign flag_z         = r_flag_z;
  assign flag_c         = r_flag_c;
  assign illegal        = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_cpu_core_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_core_mc
//  Purpose  : Directed self-checking bench for cpu_core_mc with a behavioural
//             instruction memory of programmable response delay.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_core_mc;
  localparam int DW = 8;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_core_mc_if #(.PC_WIDTH(PW)) bus ();
  logic [DW-1:0] core_output;
  logic out_valid, halted, flag_z, flag_c, illegal;

  cpu_core_mc #(.DATA_WIDTH(DW), .PC_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .imem(bus),
    .core_output(core_output), .out_valid(out_valid), .halted(halted),
    .flag_z(flag_z), .flag_c(flag_c), .illegal(illegal)
  );

  logic [15:0] mem [0:255];
  logic        mem_en = 1'b1;
  logic        noise = 1'b0;
  int          delay = 0;
  logic        mem_valid = 1'b0;
  logic [15:0] mem_rdata = 16'h0;
  logic        man_valid = 1'b0;
  logic [15:0] man_rdata = 16'h0;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [PW-1:0] a_l = '0;

  assign bus.imem_valid = mem_en ? mem_valid : man_valid;
  assign bus.imem_rdata = mem_en ? mem_rdata : man_rdata;

  // Memory: answers a request after 'delay' extra wait cycles; with noise set
  // it also drives valid with an illegal word whenever no fetch is pending.
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0; mem_valid = noise; mem_rdata = 16'hC000;
    end else if (bus.imem_req) begin
      pend = 1'b1; cnt = delay; a_l = bus.imem_addr;
      mem_valid = noise; mem_rdata = 16'hC000;
    end else if (pend) begin
      if (cnt == 0) begin mem_valid = 1'b1; mem_rdata = mem[a_l]; pend = 1'b0; end
      else begin cnt = cnt - 1; mem_valid = 1'b0; end
    end else begin
      mem_valid = noise; mem_rdata = 16'hC000;
    end
  end

  int checks = 0;
  int errors = 0;
  int outs[$];
  int addrs[$];
  int ill_cnt, ill_at, ncyc;

  function automatic logic [15:0] i_ldi(int rd, int imm);  return {4'h7, 3'(rd), 9'(imm)}; endfunction
  function automatic logic [15:0] i_r3(int op, int rd, int a, int b); return {4'(op), 3'(rd), 3'(a), 3'(b), 3'b000}; endfunction
  function automatic logic [15:0] i_addi(int rd, int a, int imm); return {4'h6, 3'(rd), 3'(a), 6'(imm)}; endfunction
  function automatic logic [15:0] i_out(int rs); return {4'h8, 3'b000, 3'(rs), 6'b0}; endfunction
  function automatic logic [15:0] i_jmp(int t); return {4'h9, 3'b000, 9'(t)}; endfunction
  function automatic logic [15:0] i_beqz(int rd, int t); return {4'hA, 3'(rd), 9'(t)}; endfunction
  localparam logic [15:0] HALT = 16'hF000;

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic load_basic();
    clear_mem();
    mem[0] = i_ldi(1, 5); mem[1] = i_ldi(2, 3); mem[2] = i_r3(1, 3, 1, 2);
    mem[3] = i_out(3);    mem[4] = HALT;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  task automatic sample(int n);
    if (bus.imem_req) addrs.push_back(int'(bus.imem_addr));
    if (out_valid) outs.push_back(int'(core_output));
    if (illegal) begin ill_cnt++; ill_at = n; end
  endtask

  // Runs the loaded program from reset; ncyc = first cycle halted seen (0 = never)
  task automatic run_prog(int max);
    outs.delete(); addrs.delete(); ill_cnt = 0; ill_at = -1; ncyc = 0;
    do_reset();
    sample(0);
    for (int n = 1; n <= max; n++) begin
      @(posedge clk); #1;
      sample(n);
      if (halted && ncyc == 0) ncyc = n;
      if (ncyc != 0 && n >= ncyc + 3) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (core_output !== 8'd0) begin errors++; $display("FAIL reset_out got %0d want 0", core_output); end
    checks++; if ({out_valid, halted, flag_z, flag_c, illegal} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b want 00000", {out_valid, halted, flag_z, flag_c, illegal}); end
    checks++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 8'd0) begin errors++; $display("FAIL reset_bus got req=%b addr=%0d want 0/0", bus.imem_req, bus.imem_addr); end
    rst = 1'b0; #1;
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL reset_first_req got %b want 1", bus.imem_req); end
  endtask

  task automatic test_basic();
    load_basic();
    run_prog(40);
    checks++; if (ncyc !== 15) begin errors++; $display("FAIL basic_halt_cycle got %0d want 15", ncyc); end
    checks++; if (addrs.size() !== 5) begin errors++; $display("FAIL basic_req_count got %0d want 5", addrs.size()); end
    checks++; if (outs.size() !== 1 || outs[0] !== 8) begin errors++; $display("FAIL basic_out got n=%0d v=%0d want n=1 v=8", outs.size(), outs[0]); end
    checks++; if ({flag_z, flag_c} !== 2'b00 || ill_cnt !== 0) begin errors++; $display("FAIL basic_flags got zc=%b ill=%0d want 00/0", {flag_z, flag_c}, ill_cnt); end
  endtask

  task automatic test_wrap_carry();
    clear_mem();
    mem[0] = i_ldi(1, 255); mem[1] = i_addi(1, 1, 1); mem[2] = i_out(1); mem[3] = HALT;
    run_prog(40);
    checks++; if (outs.size() !== 1 || outs[0] !== 0) begin errors++; $display("FAIL addi_wrap got n=%0d v=%0d want n=1 v=0", outs.size(), outs[0]); end
    checks++; if ({flag_z, flag_c} !== 2'b11) begin errors++; $display("FAIL addi_flags got zc=%b want 11", {flag_z, flag_c}); end
    clear_mem();
    mem[0] = i_ldi(1, 1); mem[1] = i_r3(2, 2, 0, 1); mem[2] = i_out(2); mem[3] = HALT;
    run_prog(40);
    checks++; if (outs.size() !== 1 || outs[0] !== 255) begin errors++; $display("FAIL sub_borrow got n=%0d v=%0d want n=1 v=255", outs.size(), outs[0]); end
    checks++; if ({flag_z, flag_c} !== 2'b01) begin errors++; $display("FAIL sub_flags got zc=%b want 01", {flag_z, flag_c}); end
  endtask

  task automatic test_logic();
    int exp_o[5] = '{8'hAC, 8'h0C, 8'hAF, 8'hA3, 8'h0E};
    clear_mem();
    mem[0] = i_ldi(1, 9'h1AC);      mem[1] = i_ldi(2, 9'h00F);
    mem[2] = i_r3(3, 3, 1, 2);      mem[3] = i_r3(4, 4, 1, 2);
    mem[4] = i_r3(5, 5, 1, 2);      mem[5] = i_addi(6, 2, -1);
    mem[6] = i_out(1); mem[7] = i_out(3); mem[8] = i_out(4); mem[9] = i_out(5); mem[10] = i_out(6);
    mem[11] = i_r3(5, 7, 2, 2);     mem[12] = HALT;
    run_prog(80);
    checks++; if (outs.size() !== 5) begin errors++; $display("FAIL logic_out_count got %0d want 5", outs.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (outs[i] !== exp_o[i]) begin errors++; $display("FAIL logic_out[%0d] got %0h want %0h", i, outs[i], exp_o[i]); end
    end
    checks++; if ({flag_z, flag_c} !== 2'b10) begin errors++; $display("FAIL logic_flags got zc=%b want 10", {flag_z, flag_c}); end
  endtask

  task automatic test_branch();
    int exp_a[7] = '{0, 1, 6, 7, 8, 9, 12};
    int exp_w[6] = '{0, 2, 3, 255, 0, 1};
    clear_mem();
    mem[0] = i_ldi(4, 0); mem[1] = i_beqz(4, 6); mem[6] = i_ldi(4, 1); mem[7] = i_beqz(4, 0);
    mem[8] = i_out(4);    mem[9] = i_jmp(12);    mem[12] = HALT;
    run_prog(60);
    checks++; if (addrs.size() !== 7) begin errors++; $display("FAIL branch_fetch_count got %0d want 7", addrs.size()); end
    for (int i = 0; i < 7; i++) begin
      checks++; if (addrs[i] !== exp_a[i]) begin errors++; $display("FAIL branch_addr[%0d] got %0d want %0d", i, addrs[i], exp_a[i]); end
    end
    checks++; if (outs.size() !== 1 || outs[0] !== 1 || ncyc !== 21) begin errors++; $display("FAIL branch_out got v=%0d cyc=%0d want 1/21", outs[0], ncyc); end
    clear_mem();
    mem[0] = i_beqz(1, 2); mem[1] = HALT; mem[2] = i_ldi(1, 9); mem[3] = i_jmp(255); mem[255] = i_out(1);
    run_prog(60);
    checks++; if (addrs.size() !== 6) begin errors++; $display("FAIL pcwrap_fetch_count got %0d want 6", addrs.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (addrs[i] !== exp_w[i]) begin errors++; $display("FAIL pcwrap_addr[%0d] got %0d want %0d", i, addrs[i], exp_w[i]); end
    end
    checks++; if (outs.size() !== 1 || outs[0] !== 9) begin errors++; $display("FAIL pcwrap_out got n=%0d v=%0d want 1/9", outs.size(), outs[0]); end
  endtask

  task automatic test_stall();
    load_basic();
    delay = 4; noise = 1'b1;
    run_prog(100);
    checks++; if (ncyc !== 35) begin errors++; $display("FAIL stall_halt_cycle got %0d want 35", ncyc); end
    checks++; if (outs.size() !== 1 || outs[0] !== 8) begin errors++; $display("FAIL stall_out got n=%0d v=%0d want 1/8", outs.size(), outs[0]); end
    checks++; if (ill_cnt !== 0 || addrs.size() !== 5) begin errors++; $display("FAIL stall_noise got ill=%0d reqs=%0d want 0/5", ill_cnt, addrs.size()); end
    delay = 0; noise = 1'b0;
  endtask

  task automatic test_illegal();
    int bad;
    int exp_a[5] = '{0, 1, 2, 3, 4};
    clear_mem();
    mem[0] = i_ldi(1, 255); mem[1] = i_addi(2, 1, 1); mem[2] = 16'hC000; mem[3] = i_out(2); mem[4] = HALT;
    run_prog(40);
    checks++; if (ill_cnt !== 1 || ill_at !== 9) begin errors++; $display("FAIL illegal_pulse got n=%0d at=%0d want 1/9", ill_cnt, ill_at); end
    checks++; if ({flag_z, flag_c} !== 2'b11) begin errors++; $display("FAIL illegal_flags got zc=%b want 11", {flag_z, flag_c}); end
    checks++; if (outs.size() !== 1 || outs[0] !== 0 || ncyc !== 15) begin errors++; $display("FAIL illegal_out got v=%0d cyc=%0d want 0/15", outs[0], ncyc); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (addrs[i] !== exp_a[i]) begin errors++; $display("FAIL illegal_addr[%0d] got %0d want %0d", i, addrs[i], exp_a[i]); end
    end
    noise = 1'b1; bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (illegal !== 1'b0 || bus.imem_req !== 1'b0 || halted !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL halted_ignores_valid got %0d bad cycles want 0", bad); end
    noise = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    load_basic();
    do_reset();
    repeat (4) @(posedge clk);
    #1;
    checks++; if (bus.imem_addr !== 8'd1 || bus.imem_req !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL midwait_pre got addr=%0d req=%b halted=%b want 1/0/0", bus.imem_addr, bus.imem_req, halted); end
    mem_en = 1'b0; man_valid = 1'b1; man_rdata = i_out(1); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.imem_addr !== 8'd0 || core_output !== 8'd0) begin errors++; $display("FAIL midwait_reset got addr=%0d out=%0d want 0/0", bus.imem_addr, core_output); end
    rst = 1'b0; #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'd0) begin errors++; $display("FAIL midwait_refetch got req=%b addr=%0d want 1/0", bus.imem_req, bus.imem_addr); end
    @(posedge clk); #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL midwait_wait got req=%b want 0", bus.imem_req); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b1 || core_output !== 8'd0) begin errors++; $display("FAIL midwait_regs_cleared got ov=%b out=%0d want 1/0", out_valid, core_output); end
    man_valid = 1'b0; mem_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap_carry();
    test_logic();
    test_branch();
    test_stall();
    test_illegal();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
